pe_dbw: RTL and testbench

Parametrised weight-stationary processing element for the systolic array, with a double-buffered weight register. Next-generation replacement for the fixed 8-bit PE. Weights for the next tile shift down a per-column load chain into a shadow register while the current tile computes with the active weight. A single swap pulse promotes the shadow weight to active, so the array is not stalled between tiles. Activations flow left to right, partial sums flow top to bottom.

---
 rtl/pe_dbw.sv | 105 ++++++++++
 tb/tb_pe_dbw.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_dbw.sv
// Weight-stationary systolic PE with a double-buffered weight (shadow/active).
// Optional macro PE_SAT_EN: MAC sum saturates instead of wrapping.
module pe_dbw #(
    parameter int X_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [X_W-1:0]   x_i,
    input  logic             x_v_i,
    input  logic [ACC_W-1:0] mac_i,
    input  logic             mac_v_i,
    input  logic [W_W-1:0]   w_i,
    input  logic             w_v_i,
    input  logic             w_swap_i,
    output logic [X_W-1:0]   x_o,
    output logic             x_v_o,
    output logic [ACC_W-1:0] mac_o,
    output logic             mac_v_o,
    output logic [W_W-1:0]   w_o,
    output logic             w_v_o,
    output logic             w_rdy_o
);

    typedef enum logic {
        W_EMPTY,
        W_LOADED
    } wst_t;

    wst_t st_q, st_d;

    logic [W_W-1:0]       w_sh_q;
    logic [W_W-1:0]       w_act_q;
    logic                 fire;
    logic [X_W+W_W-1:0]   prod;
    logic [ACC_W:0]       sum_ext;
    logic [ACC_W-1:0]     mac_nxt;

    assign fire    = x_v_i & mac_v_i;
    assign prod    = x_i * w_act_q;
    assign sum_ext = (ACC_W+1)'(mac_i) + (ACC_W+1)'(prod);

`ifdef PE_SAT_EN
    assign mac_nxt = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
    assign mac_nxt = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q <= W_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    // A load in the same cycle as a swap keeps the shadow occupied
    always_comb begin
        st_d = st_q;
        case (st_q)
            W_EMPTY: begin
                if (w_v_i)
                    st_d = W_LOADED;
            end
            W_LOADED: begin
                if (w_swap_i && !w_v_i)
                    st_d = W_EMPTY;
            end
            default: st_d = W_EMPTY;
        endcase
    end

    always_comb begin
        w_rdy_o = (st_q == W_LOADED);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            x_o     <= '0;
            x_v_o   <= 1'b0;
            mac_o   <= '0;
            mac_v_o <= 1'b0;
            w_o     <= '0;
            w_v_o   <= 1'b0;
            w_sh_q  <= '0;
            w_act_q <= '0;
        end else begin
            x_v_o   <= x_v_i;
            mac_v_o <= fire;
            w_v_o   <= w_v_i;
            if (x_v_i)
                x_o <= x_i;
            if (fire)
                mac_o <= mac_nxt;
            if (w_v_i) begin
                w_o    <= w_i;
                w_sh_q <= w_i;
            end
            if (w_swap_i)
                w_act_q <= w_sh_q;
        end
    end

endmodule

// File: tb/tb_pe_dbw.sv
// Directed bench for pe_dbw: reset, MAC, double buffering, swap/load overlap,
// partial valid and overflow.
module tb_pe_dbw;

    localparam int X_W   = 8;
    localparam int W_W   = 8;
    localparam int ACC_W = 19;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [X_W-1:0]   x_i;
    logic             x_v_i;
    logic [ACC_W-1:0] mac_i;
    logic             mac_v_i;
    logic [W_W-1:0]   w_i;
    logic             w_v_i;
    logic             w_swap_i;
    logic [X_W-1:0]   x_o;
    logic             x_v_o;
    logic [ACC_W-1:0] mac_o;
    logic             mac_v_o;
    logic [W_W-1:0]   w_o;
    logic             w_v_o;
    logic             w_rdy_o;

    int checks   = 0;
    int failures = 0;

    pe_dbw #(.X_W(X_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .x_i      (x_i),
        .x_v_i    (x_v_i),
        .mac_i    (mac_i),
        .mac_v_i  (mac_v_i),
        .w_i      (w_i),
        .w_v_i    (w_v_i),
        .w_swap_i (w_swap_i),
        .x_o      (x_o),
        .x_v_o    (x_v_o),
        .mac_o    (mac_o),
        .mac_v_o  (mac_v_o),
        .w_o      (w_o),
        .w_v_o    (w_v_o),
        .w_rdy_o  (w_rdy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic xv,
                         input logic [18:0] m, input logic mv,
                         input logic [7:0] w, input logic wv,
                         input logic sw);
        x_i = x; x_v_i = xv; mac_i = m; mac_v_i = mv;
        w_i = w; w_v_i = wv; w_swap_i = sw;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_x_o"},     32'(x_o),     0);
        chk({pfx, "_x_v_o"},   32'(x_v_o),   0);
        chk({pfx, "_mac_o"},   32'(mac_o),   0);
        chk({pfx, "_mac_v_o"}, 32'(mac_v_o), 0);
        chk({pfx, "_w_o"},     32'(w_o),     0);
        chk({pfx, "_w_v_o"},   32'(w_v_o),   0);
        chk({pfx, "_w_rdy_o"}, 32'(w_rdy_o), 0);
    endtask

    initial begin
        logic [31:0] ovf_exp;
        rst_i = 1'b0;
        drive(8'd0, 0, 19'd0, 0, 8'd0, 0, 0);
        #12;
        chk_all_zero("rst");
        #4 rst_i = 1'b1;

        // fire with w_act = 0 passes mac_i through
        drive(8'd1, 1, 19'd5, 1, 8'd0, 0, 0);
        step();
        chk("zero_w_mac", 32'(mac_o), 5);
        chk("zero_w_mac_v", 32'(mac_v_o), 1);
        chk("zero_w_x", 32'(x_o), 1);

        // basic MAC
        drive(8'd0, 0, 19'd0, 0, 8'd3, 1, 0);
        step();
        chk("ld3_w_o", 32'(w_o), 3);
        chk("ld3_w_v_o", 32'(w_v_o), 1);
        chk("ld3_rdy", 32'(w_rdy_o), 1);
        chk("ld3_mac_hold", 32'(mac_o), 5);
        chk("ld3_mac_v", 32'(mac_v_o), 0);
        drive(8'd0, 0, 19'd0, 0, 8'd0, 0, 1);
        step();
        chk("sw3_rdy", 32'(w_rdy_o), 0);
        chk("sw3_w_v_o", 32'(w_v_o), 0);
        chk("sw3_w_o_hold", 32'(w_o), 3);
        drive(8'd7, 1, 19'd10, 1, 8'd0, 0, 0);
        step();
        chk("basic_mac", 32'(mac_o), 31);
        chk("basic_mac_v", 32'(mac_v_o), 1);
        chk("basic_x", 32'(x_o), 7);
        chk("basic_x_v", 32'(x_v_o), 1);

        // double buffer: load 9 while computing with 3
        drive(8'd2, 1, 19'd0, 1, 8'd9, 1, 0);
        step();
        chk("db_mac0", 32'(mac_o), 6);
        chk("db_rdy0", 32'(w_rdy_o), 1);
        drive(8'd2, 1, 19'd0, 1, 8'd0, 0, 0);
        step();
        chk("db_mac1", 32'(mac_o), 6);
        drive(8'd2, 1, 19'd0, 1, 8'd0, 0, 1);
        step();
        chk("db_swap_old_w", 32'(mac_o), 6);
        chk("db_rdy_sw", 32'(w_rdy_o), 0);
        drive(8'd2, 1, 19'd0, 1, 8'd0, 0, 0);
        step();
        chk("db_new_w", 32'(mac_o), 18);

        // simultaneous swap and load
        drive(8'd0, 0, 19'd0, 0, 8'd4, 1, 0);
        step();
        drive(8'd0, 0, 19'd0, 0, 8'd5, 1, 1);
        step();
        chk("simul_w_o", 32'(w_o), 5);
        chk("simul_w_v_o", 32'(w_v_o), 1);
        chk("simul_rdy", 32'(w_rdy_o), 1);
        drive(8'd1, 1, 19'd0, 1, 8'd0, 0, 0);
        step();
        chk("simul_w_act4", 32'(mac_o), 4);
        drive(8'd0, 0, 19'd0, 0, 8'd0, 0, 1);
        step();
        chk("simul_rdy_clr", 32'(w_rdy_o), 0);
        drive(8'd1, 1, 19'd0, 1, 8'd0, 0, 0);
        step();
        chk("simul_w_sh5", 32'(mac_o), 5);

        // swap with empty shadow recopies the same weight
        drive(8'd0, 0, 19'd0, 0, 8'd0, 0, 1);
        step();
        chk("reswap_rdy", 32'(w_rdy_o), 0);
        drive(8'd3, 1, 19'd1, 1, 8'd0, 0, 0);
        step();
        chk("reswap_mac", 32'(mac_o), 16);

        // partial valid
        drive(8'd9, 1, 19'd100, 0, 8'd0, 0, 0);
        step();
        chk("pv_x_mac_hold", 32'(mac_o), 16);
        chk("pv_x_mac_v", 32'(mac_v_o), 0);
        chk("pv_x_x_o", 32'(x_o), 9);
        drive(8'd44, 0, 19'd77, 1, 8'd0, 0, 0);
        step();
        chk("pv_m_mac_hold", 32'(mac_o), 16);
        chk("pv_m_mac_v", 32'(mac_v_o), 0);
        chk("pv_m_x_v", 32'(x_v_o), 0);
        chk("pv_m_x_hold", 32'(x_o), 9);

        // overflow boundary with 255 x 255
        drive(8'd0, 0, 19'd0, 0, 8'd255, 1, 0);
        step();
        drive(8'd0, 0, 19'd0, 0, 8'd0, 0, 1);
        step();
        drive(8'd255, 1, 19'd459262, 1, 8'd0, 0, 0);
        step();
        chk("ovf_edge", 32'(mac_o), 524287);
`ifdef PE_SAT_EN
        ovf_exp = 524287;
`else
        ovf_exp = 65024;
`endif
        drive(8'd255, 1, 19'd524287, 1, 8'd0, 0, 0);
        step();
        chk("ovf", 32'(mac_o), ovf_exp);

        // asynchronous reset mid-stream
        drive(8'd6, 1, 19'd40, 1, 8'd8, 1, 1);
        step();
        #2 rst_i = 1'b0;
        #1;
        chk_all_zero("arst");
        #3 rst_i = 1'b1;
        drive(8'd7, 1, 19'd5, 1, 8'd0, 0, 0);
        step();
        chk("post_rst_mac", 32'(mac_o), 5);
        chk("post_rst_mac_v", 32'(mac_v_o), 1);
        chk("post_rst_rdy", 32'(w_rdy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
